// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the hardwired control sequencer: T-step states, opcode and
// ALU encodings, the strobe bundle and opcode classification helpers.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RST  = 3'd0,
        ST_T0   = 3'd1,
        ST_T1   = 3'd2,
        ST_T2   = 3'd3,
        ST_T3   = 3'd4,
        ST_T4   = 3'd5,
        ST_T5   = 3'd6,
        ST_HALT = 3'd7
    } state_t;

    localparam int OPC_BITS = 5;
    typedef logic [OPC_BITS-1:0] opc_t;

    localparam opc_t OPC_ADD  = 5'b00011;
    localparam opc_t OPC_SUB  = 5'b00100;
    localparam opc_t OPC_AND  = 5'b00101;
    localparam opc_t OPC_OR   = 5'b00110;
    localparam opc_t OPC_ADDI = 5'b01100;
    localparam opc_t OPC_ORI  = 5'b01101;
    localparam opc_t OPC_ANDI = 5'b01110;
    localparam opc_t OPC_HALT = 5'b11011;

    // The ALU decodes the same values the instruction carries
    localparam opc_t ALU_ADD  = OPC_ADD;
    localparam opc_t ALU_SUB  = OPC_SUB;
    localparam opc_t ALU_AND  = OPC_AND;
    localparam opc_t ALU_OR   = OPC_OR;
    localparam opc_t ALU_ADDI = OPC_ADDI;
    localparam opc_t ALU_ORI  = OPC_ORI;
    localparam opc_t ALU_ANDI = OPC_ANDI;

    typedef struct packed {
        logic pc_out;
        logic zhi_out;
        logic zlow_out;
        logic mdr_out;
        logic mar_in;
        logic z_in;
        logic pc_in;
        logic mdr_in;
        logic ir_in;
        logic y_in;
        logic inc_pc;
        logic read;
        logic write;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
        logic ba_out;
        logic c_out;
        opc_t alu_op;
    } ctrl_t;

    function automatic logic is_imm(input opc_t opc);
        return (opc == OPC_ADDI) || (opc == OPC_ORI) || (opc == OPC_ANDI);
    endfunction

    function automatic logic is_reg(input opc_t opc);
        return (opc == OPC_ADD) || (opc == OPC_SUB) || (opc == OPC_AND) || (opc == OPC_OR);
    endfunction

    function automatic logic is_alu(input opc_t opc);
        return is_reg(opc) || is_imm(opc);
    endfunction

    function automatic opc_t alu_sel(input opc_t opc);
        opc_t sel;
        case (opc)
            OPC_ADD:  sel = ALU_ADD;
            OPC_SUB:  sel = ALU_SUB;
            OPC_AND:  sel = ALU_AND;
            OPC_OR:   sel = ALU_OR;
            OPC_ADDI: sel = ALU_ADDI;
            OPC_ORI:  sel = ALU_ORI;
            OPC_ANDI: sel = ALU_ANDI;
            default:  sel = '0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive T1 cycles without mem_ready and flags the cycle whose
// increment would reach WAIT_MAX.
module mem_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_timeout
);
    localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

    logic [CW-1:0] r_cnt;

    // Any cycle that is not a stall (including the T1 exit) restarts the count
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr)
            r_cnt <= '0;
        else if (i_inc)
            r_cnt <= r_cnt + 1'b1;
        else
            r_cnt <= '0;
    end

    assign o_timeout = i_inc && (r_cnt == CW'(WAIT_MAX - 1));

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer for register and immediate ALU
// instructions, with memory-wait stalling, timeout, stop/halt and retire count.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPC_W    = 5,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic [31:0]      IR,
    input  logic             mem_ready,
    input  logic             Stop,
    output logic             PCout,
    output logic             Zhiout,
    output logic             Zlowout,
    output logic             MDRout,
    output logic             MARin,
    output logic             Zin,
    output logic             PCin,
    output logic             MDRin,
    output logic             IRin,
    output logic             Yin,
    output logic             IncPC,
    output logic             Read,
    output logic             Write,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             Rin,
    output logic             Rout,
    output logic             BAout,
    output logic             Cout,
    output logic [4:0]       alu_op,
    output logic             Run,
    output logic             bus_err,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t           r_state;
    state_t           w_next;
    logic [OPC_W-1:0] r_opc;
    logic             r_bus_err;
    logic             r_illegal;
    logic [CNT_W-1:0] r_cnt;

    opc_t  w_opc;
    ctrl_t w_ctl;
    logic  w_in_t1;
    logic  w_timeout;
    logic  w_retire;
    logic  w_unused_ir;

    assign w_opc       = opc_t'(r_opc);
    assign w_in_t1     = (r_state == ST_T1);
    assign w_unused_ir = ^IR[31-OPC_W:0];

    mem_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait (
        .i_clk     (Clock),
        .i_rst_n   (Clear),
        .i_clr     (!w_in_t1),
        .i_inc     (w_in_t1 && !mem_ready),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge Clock) begin
        if (!Clear)
            r_state <= ST_RST;
        else
            r_state <= w_next;
    end

    // mem_ready takes priority over a timeout landing on the same edge
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RST:  w_next = ST_T0;
            ST_T0:   w_next = ST_T1;
            ST_T1: begin
                if (mem_ready)
                    w_next = ST_T2;
                else if (w_timeout)
                    w_next = ST_HALT;
            end
            ST_T2:   w_next = ST_T3;
            ST_T3:   w_next = ST_T4;
            ST_T4:   w_next = is_alu(w_opc) ? ST_T5 : ST_HALT;
            ST_T5:   w_next = Stop ? ST_HALT : ST_T0;
            ST_HALT: w_next = ST_HALT;
            default: w_next = ST_RST;
        endcase
    end

    // HALT opcodes retire; undefined opcodes do not
    assign w_retire = (r_state == ST_T5) ||
                      ((r_state == ST_T4) && (w_opc == OPC_HALT));

    always_ff @(posedge Clock) begin
        if (!Clear) begin
            r_opc     <= '0;
            r_bus_err <= 1'b0;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (r_state == ST_T3)
                r_opc <= IR[31 -: OPC_W];
            if (w_in_t1 && !mem_ready && w_timeout)
                r_bus_err <= 1'b1;
            if ((r_state == ST_T4) && !is_alu(w_opc) && (w_opc != OPC_HALT))
                r_illegal <= 1'b1;
            if (w_retire)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_ctl = '0;
        case (r_state)
            ST_T0: begin
                w_ctl.pc_out = 1'b1;
                w_ctl.mar_in = 1'b1;
                w_ctl.inc_pc = 1'b1;
                w_ctl.z_in   = 1'b1;
            end
            ST_T1: begin
                w_ctl.zlow_out = 1'b1;
                w_ctl.pc_in    = 1'b1;
                w_ctl.read     = 1'b1;
                w_ctl.mdr_in   = 1'b1;
            end
            ST_T2: begin
                w_ctl.mdr_out = 1'b1;
                w_ctl.ir_in   = 1'b1;
            end
            ST_T3: begin
                w_ctl.grb   = 1'b1;
                w_ctl.r_out = 1'b1;
                w_ctl.y_in  = 1'b1;
            end
            ST_T4: begin
                if (is_alu(w_opc)) begin
                    w_ctl.z_in   = 1'b1;
                    w_ctl.alu_op = alu_sel(w_opc);
                    if (is_imm(w_opc)) begin
                        w_ctl.c_out = 1'b1;
                    end else begin
                        w_ctl.grc   = 1'b1;
                        w_ctl.r_out = 1'b1;
                    end
                end
            end
            ST_T5: begin
                w_ctl.zlow_out = 1'b1;
                w_ctl.gra      = 1'b1;
                w_ctl.r_in     = 1'b1;
            end
            default: w_ctl = '0;
        endcase
    end

    assign PCout     = w_ctl.pc_out;
    assign Zhiout    = w_ctl.zhi_out;
    assign Zlowout   = w_ctl.zlow_out;
    assign MDRout    = w_ctl.mdr_out;
    assign MARin     = w_ctl.mar_in;
    assign Zin       = w_ctl.z_in;
    assign PCin      = w_ctl.pc_in;
    assign MDRin     = w_ctl.mdr_in;
    assign IRin      = w_ctl.ir_in;
    assign Yin       = w_ctl.y_in;
    assign IncPC     = w_ctl.inc_pc;
    assign Read      = w_ctl.read;
    assign Write     = w_ctl.write;
    assign Gra       = w_ctl.gra;
    assign Grb       = w_ctl.grb;
    assign Grc       = w_ctl.grc;
    assign Rin       = w_ctl.r_in;
    assign Rout      = w_ctl.r_out;
    assign BAout     = w_ctl.ba_out;
    assign Cout      = w_ctl.c_out;
    assign alu_op    = w_ctl.alu_op;
    assign Run       = (r_state != ST_RST) && (r_state != ST_HALT);
    assign bus_err   = r_bus_err;
    assign illegal   = r_illegal;
    assign instr_cnt = r_cnt;

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit that drives the datapath's control strobes through the fetch, decode and execute T-steps. It replaces hand-sequenced control for register-register and register-immediate ALU instructions. It sits beside the datapath: it consumes the IR output and the memory ready flag, and emits every `*in`/`*out` strobe plus the ALU opcode. It is parametrised in opcode width, memory wait tolerance and instruction-counter width, and adds memory-wait stalling, timeout, stop/halt and instruction counting.

## Interface
Parameters:
- `OPC_W`, 5: opcode field width; the opcode is `IR[31:32-OPC_W]`.
- `WAIT_MAX`, 15: maximum number of cycles to wait for `mem_ready` in T1 before a bus error.
- `CNT_W`, 16: width of the retired-instruction counter.

Ports:
- `Clock` in 1: single clock; all state changes on the rising edge.
- `Clear` in 1: reset, synchronous, active-low.
- `IR` in 32: datapath instruction register.
- `mem_ready` in 1: memory read data valid.
- `Stop` in 1: level; requests a halt at the next instruction boundary.
- `PCout, Zhiout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read, Write` out 1 each: datapath strobes.
- `Gra, Grb, Grc, Rin, Rout, BAout, Cout` out 1 each: register-select and constant strobes.
- `alu_op` out 5: ALU function, valid only while `Zin` is high in T4.
- `Run` out 1: high while sequencing.
- `bus_err` out 1: sticky flag, set on memory timeout.
- `illegal` out 1: sticky flag, set on an undefined opcode.
- `instr_cnt` out `CNT_W`: count of retired instructions.

## Operation
- States are RST, T0, T1, T2, T3, T4, T5 and HALT.
- Outputs are Moore, decoded from the state register and the latched opcode only.
- T0: `PCout`, `MARin`, `IncPC` and `Zin` are high.
- T1: `Zlowout`, `PCin`, `Read` and `MDRin` are high.
- T2: `MDRout` and `IRin` are high. The opcode is latched from `IR` on the T3→T4 edge, when the IR is stable.
- T3: `Grb`, `Rout` and `Yin` are high.
- T4, register form: `Grc`, `Rout` and `Zin` are high; `alu_op` is set from the opcode.
- T4, immediate form: `Cout` and `Zin` are high; `alu_op` is set from the opcode.
- T5: `Zlowout`, `Gra` and `Rin` are high. `instr_cnt` increments on the T5 exit edge and wraps to 0 at 2^CNT_W.
- HALT opcode: T4 goes directly to HALT. No strobes are asserted and `instr_cnt` still increments.
- Undefined opcode: T4 goes to HALT and `illegal` is set. No strobes are asserted and `instr_cnt` does not increment.
- The `Write`, `BAout` and `Zhiout` ports are present for later load/store and multiply/divide work and are held at 0 in this revision.

## Timing
- Reset: a low `Clear` sampled at a rising edge forces RST. This applies from any state, including mid-stall in T1.
- In RST all strobes are 0, `Run`=0, `bus_err`=0, `illegal`=0, `instr_cnt`=0 and the wait counter is 0.
- RST→T0 on the first edge after `Clear` returns high.
- Normal transitions: T0→T1 and T2→T3→T4→T5.
- T1 stall: T1 holds while `mem_ready`=0, with the T1 strobes held and the wait counter incrementing.
- T1 exit: T1→T2 on the edge where `mem_ready`=1 is sampled, and the wait counter clears.
- Timeout: if the wait counter reaches `WAIT_MAX` with `mem_ready` still 0, T1→HALT and `bus_err` is set.
- `mem_ready` on the same edge as the timeout wins, and the machine goes to T2.
- No stall: an instruction is 6 cycles, T0 through T5.
- Stop: `Stop` sampled high at the T5 exit edge sends T5→HALT instead of T0. The current instruction completes and is counted.
- HALT is terminal. Only reset leaves it.
- `Run` is 1 in T0–T5 and 0 in RST and HALT.

## Structure
- Package `cpu_ctrl_pkg` holds the state enum and the opcode constants: ADD=00011, SUB=00100, AND=00101, OR=00110, ADDI=01100, ORI=01101, ANDI=01110, HALT=11011.
- The package also holds the `alu_op` encodings (same values as the opcode) and the function `is_imm(opc)`.
- One sub-module, `mem_wait_timer`, holds the wait counter and the timeout compare. It is parametrised by `WAIT_MAX` and cleared by the sequencer in any state other than T1.

## Test plan
- ORI: `IR`=0x6908001A (ori R2,R1,26) with `mem_ready` tied high → T0–T5 in 6 cycles. T4 has `Cout`=1, `Zin`=1, `alu_op`=01101; T5 has `Gra`=1, `Rin`=1; `instr_cnt`=1.
- ADD: `IR`=0x1A218000 → T4 has `Grc`=1, `Rout`=1, `alu_op`=00011 and `Cout`=0.
- Memory wait: `mem_ready` low for 3 cycles in T1 → T1 lasts 4 cycles with `Read`/`MDRin` held, and the instruction takes 9 cycles.
- Timeout: `mem_ready` held low, `WAIT_MAX`=4 → HALT after 4 T1 cycles with `bus_err`=1 and `Run`=0.
- Stop and HALT opcode:
  - `Stop` asserted in T3 → the instruction finishes, T5→HALT, `instr_cnt`=1.
  - Opcode 11011 → HALT from T4.
  - Opcode 11111 → `illegal`=1.
- Reset mid-op: `Clear` low during a T1 stall → next edge RST with all outputs 0. Releasing `Clear` restarts at T0 with `instr_cnt`=0.
